// File: rtl/ant_cmd_tx_pkg.sv
// Shared definitions for the ant-farm cell command link: opcodes, cell codes,
// link bit positions and the transmitter FSM state encoding.
package ant_pkg;

  localparam logic [4:0] OP_NOP       = 5'd0;
  localparam logic [4:0] OP_E         = 5'd1;
  localparam logic [4:0] OP_G         = 5'd2;
  localparam logic [4:0] OP_T         = 5'd3;
  localparam logic [4:0] OP_Q         = 5'd4;
  localparam logic [4:0] OP_NS_NA     = 5'd5;
  localparam logic [4:0] OP_NS_ANT    = 5'd6;
  localparam logic [4:0] OP_SUGAR_NA  = 5'd7;
  localparam logic [4:0] OP_SUGAR_ANT = 5'd8;

  typedef enum logic [1:0] {
    CELL_E = 2'd0,
    CELL_G = 2'd1,
    CELL_T = 2'd2,
    CELL_Q = 2'd3
  } cell_t;

  localparam int LINK_W      = 6;
  localparam int LINK_STROBE = 5;
  localparam int LINK_OP_HI  = 4;
  localparam int LINK_OP_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } tx_state_t;

  function automatic logic op_legal(input logic [4:0] op);
    return (op != OP_NOP) && (op <= OP_SUGAR_ANT);
  endfunction

endpackage

// File: rtl/ant_cmd_tx_if.sv
// Request handshake from the game controller plus the North-edge command link.
// The transmitter uses the slave modport; the controller/grid side uses master.
interface ant_cmd_tx_if #(
  parameter int COLS = 8,
  parameter int ROWS = 8
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [COL_W-1:0] req_col;
  logic [ROW_W-1:0] req_row;
  logic [4:0]       req_op;
  logic [5:0]       link_data;
  logic [COL_W-1:0] link_col;
  logic [ROW_W-1:0] link_row;
  logic             link_ack;

  modport master (
    output req_valid, req_col, req_row, req_op, link_ack,
    input  req_ready, link_data, link_col, link_row
  );

  modport slave (
    input  req_valid, req_col, req_row, req_op, link_ack,
    output req_ready, link_data, link_col, link_row
  );
endinterface

// File: rtl/ant_cmd_tx_fifo.sv
// Synchronous request FIFO with occupancy count; the head entry is visible
// combinationally and only leaves on pop.
module ant_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so full is exactly the count MSB
  assign full    = cnt[PTR_W];
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ant_cmd_tx.sv
// Cell command transmitter: buffers requests, strobes them onto the link,
// waits for ack with timeout/retry. ANT_CMD_TX_BROADCAST_EN enables row broadcast.
module ant_cmd_tx
  import ant_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int MAX_RETRY   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ant_cmd_tx_if.slave                 bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_badop,
  output logic                        err_timeout
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ENT_W = COL_W + ROW_W + 5;
  localparam int TMR_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  tx_state_t        state, state_d;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retries;
  logic [4:0]       cur_op;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;

  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [ENT_W-1:0] head;
  logic [COL_W-1:0] head_col;
  logic [ROW_W-1:0] head_row;
  logic [4:0]       head_op;
  logic             accept, row_ok, req_legal;
  logic             load, tmr_clr, tmr_inc, rty_clr, rty_inc, drop;

  assign {head_col, head_row, head_op} = head;

  // Request intake: illegal entries are swallowed here and never reach the FIFO
`ifdef ANT_CMD_TX_BROADCAST_EN
  localparam bit ROW_SPARE = (ROWS < (1 << ROW_W));
  logic cur_bcast;
  assign row_ok = (int'(bus.req_row) < ROWS) || (ROW_SPARE && (&bus.req_row));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cur_bcast <= 1'b0;
    else if (load) cur_bcast <= ROW_SPARE && (&head_row);
  end
`else
  logic cur_bcast;
  assign row_ok    = (int'(bus.req_row) < ROWS);
  assign cur_bcast = 1'b0;
`endif

  assign bus.req_ready = !fifo_full;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_legal     = op_legal(bus.req_op) && row_ok;
  assign fifo_push     = accept && req_legal;

  ant_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({bus.req_col, bus.req_row, bus.req_op}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Link FSM: next state and control strobes
  always_comb begin
    state_d  = state;
    fifo_pop = 1'b0;
    load     = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    rty_clr  = 1'b0;
    rty_inc  = 1'b0;
    drop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cur_bcast) begin
          fifo_pop = 1'b1;
          rty_clr  = 1'b1;
          state_d  = ST_GAP;
        end else begin
          tmr_inc = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        tmr_inc = 1'b1;
        if (bus.link_ack) begin
          fifo_pop = 1'b1;
          rty_clr  = 1'b1;
          state_d  = ST_GAP;
        end else if (timer == TMR_W'(ACK_TIMEOUT)) begin
          if (retries < RTY_W'(MAX_RETRY)) begin
            rty_inc = 1'b1;
          end else begin
            fifo_pop = 1'b1;
            rty_clr  = 1'b1;
            drop     = 1'b1;
          end
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // A non-zero retry count means the head entry is being re-issued
        if (retries != '0) begin
          tmr_clr = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      retries     <= '0;
      cur_op      <= '0;
      cur_col     <= '0;
      cur_row     <= '0;
      err_badop   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_d;
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + 1'b1;
      if (rty_clr)      retries <= '0;
      else if (rty_inc) retries <= retries + 1'b1;
      if (load) begin
        cur_op  <= head_op;
        cur_col <= head_col;
        cur_row <= head_row;
      end
      err_badop   <= accept && !req_legal;
      err_timeout <= drop;
    end
  end

  // Link outputs decode straight from state so reset clears them at once
  always_comb begin
    bus.link_data = '0;
    case (state)
      ST_ISSUE:    bus.link_data = {1'b1, cur_op};
      ST_WAIT_ACK: bus.link_data = {1'b0, cur_op};
      default:     bus.link_data = '0;
    endcase
  end

  assign bus.link_col = cur_col;
  assign bus.link_row = cur_row;
  assign busy         = !fifo_empty || (state != ST_IDLE);
endmodule

// File: doc/ant_cmd_tx.md
Name: ant_cmd_tx

Overview:
- Command transmitter for the ant-farm cell grid: the issuing end of the cell command link that grid cells decode.
- Accepts cell-update requests (column, row, opcode) from the game controller and buffers them in a small FIFO.
- Serialises each request onto the grid's North-edge command link, waits for the target cell's acknowledge, and retries or reports on timeout.

Parameters:
- COLS, 8, grid columns; COL_W = clog2(COLS).
- ROWS, 8, grid rows; ROW_W = clog2(ROWS).
- FIFO_DEPTH, 4, request buffer entries (power of 2, ≥2).
- ACK_TIMEOUT, 15, cycles in WAIT_ACK before a timeout.
- MAX_RETRY, 2, re-issues after the first attempt before a request is dropped.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_col  in  COL_W  target column
- req_row  in  ROW_W  target row
- req_op  in  5  opcode: 1=E, 2=G, 3=T, 4=Q, 5=no sugar/no ant, 6=no sugar/ant, 7=sugar/no ant, 8=sugar/ant
- link_data  out  6  bit5 = strobe, bits4:0 = opcode; 0 means idle/NOP
- link_col  out  COL_W  column being driven
- link_row  out  ROW_W  row addressed
- link_ack  in  1  target cell acknowledge, single-cycle pulse
- busy  out  1  FIFO non-empty or FSM not IDLE
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy
- err_badop  out  1  one-cycle pulse: illegal opcode was consumed
- err_timeout  out  1  one-cycle pulse: request dropped after all retries

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; FSM in IDLE; retry and timeout counters 0.
  - link_data=0, link_col=0, link_row=0, busy=0, err_*=0, fifo_count=0.
  - req_ready=1 once reset releases.
- Reset mid-transaction aborts immediately: link_data returns to 0 and FIFO contents are discarded.
- Request intake:
  - req_ready = !full.
  - Accept on req_valid && req_ready.
  - Opcode 0 or 9..31: consumed, not enqueued; err_badop pulses the next cycle.
  - Simultaneous push and pop while full: the pop frees a slot in the same cycle, but req_ready stays combinationally !full. No bypass.
- FSM:
  - IDLE: if FIFO non-empty, latch the head into the output registers and go to ISSUE. The head stays in the FIFO until completion.
  - ISSUE: one cycle, link_data={1,op}, link_col/link_row valid. Go to WAIT_ACK. The timer loads 0.
  - WAIT_ACK: link_data={0,op} (strobe low, opcode held).
    - link_ack: pop the FIFO, clear retries, go to GAP.
    - timer==ACK_TIMEOUT with retries<MAX_RETRY: retries++, go to GAP, then re-ISSUE the same entry.
    - Otherwise: pop, pulse err_timeout, go to GAP.
  - GAP: one cycle with link_data=0, so cells see op 0 between commands. Then go to IDLE, or to ISSUE directly for a retry.
- Acknowledge rules:
  - link_ack is ignored outside WAIT_ACK.
  - link_ack in the same cycle as the timeout: the ack wins.
- Latency:
  - Accept into an empty FIFO in cycle N gives the strobe in cycle N+2.
  - Minimum command spacing is 4 cycles (IDLE, ISSUE, WAIT_ACK with ack, GAP).
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: ANT_CMD_TX_BROADCAST_EN.
- Defined: req_row all-ones (and ROWS < 2^ROW_W) is a column broadcast.
  - ISSUE drives link_row all-ones.
  - WAIT_ACK is skipped: ISSUE goes to GAP, and the entry is popped with no ack or retry.
- Undefined: an all-ones row with ROWS < 2^ROW_W is treated as out-of-range. It is consumed with an err_badop pulse.

Decomposition:
- Shared package ant_pkg:
  - Opcode constants OP_NOP..OP_SUGAR_ANT (0..8).
  - Cell type codes E=0, G=1, T=2, Q=3 (2-bit).
  - Link bit positions: STROBE=5, OP=4:0.
  - FSM state enum.
- One sub-module: ant_cmd_fifo, a synchronous FIFO with count, holding {col,row,op} entries and exposing head data, push, and pop.

Test Plan:
- Single request: col=3, row=5, op=2 → strobe cycle N+2 with link_data=6'b100010, link_col=3, link_row=5. Ack at N+4 → link_data=0 at N+5; busy falls.
- Illegal opcodes: op=0 and op=12 → both consumed (req_ready=1), err_badop pulses twice, nothing driven on the link.
- Back-pressure: push 5 requests with no acks, FIFO_DEPTH=4 → req_ready=0 after 4 accepts, fifo_count=4. The 5th is held until the first pop.
- Timeout/retry: never ack op=7 → 3 strobes spaced ACK_TIMEOUT+2 cycles apart, then err_timeout pulses once, entry dropped, next request issued.
- Ack on the timeout cycle: link_ack coincident with timer==15 → success, no retry strobe, err_timeout=0.
- Reset mid-WAIT_ACK with 2 entries queued → link_data=0 immediately, fifo_count=0, no strobes after release until a new request arrives.
